// File: rtl/fast_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fast_wb_arbiter
//
// Shares the single FastCore writeback port between NUM_REQ ALU lanes. Each
// lane owns a one-entry holding slot. A round-robin scheduler picks one full
// slot per cycle. The chosen beat appears on the registered wb_* outputs for a
// result, or on the registered br_* outputs for a branch resolution.
//
// Optional feature (macro FAST_WB_BRANCH_PRIO_EN):
//   defined   : full branch slots win the grant ahead of result slots, in
//               round-robin order from rr_ptr. rr_ptr still advances past the
//               winner.
//   undefined : pure round-robin. Branch and result beats are treated alike.
//
// Handshake (valid/ready): a lane beat transfers on a posedge where
// req_valid[i] && req_ready[i]. req_ready[i] is combinational:
// !flush && (slot i empty || slot i granted this cycle). A granted slot can
// therefore be refilled on the same edge. req_valid may drop without a
// transfer, and no ordering is kept across lanes.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   flush                  synchronous drop of all pending work
//   req_valid/req_ready    per-lane handshake
//   req_data/req_idx       per-lane result and destination (lane i at slice i)
//   req_is_br/req_taken    per-lane branch marker and outcome
//   wb_valid/wb_data/wb_idx       registered SRF write
//   br_resolved/br_taken          registered branch resolution
//   pending                slot-full mask
// -----------------------------------------------------------------------------
module fast_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*IDX_W-1:0]  req_idx,
  input  logic [NUM_REQ-1:0]        req_is_br,
  input  logic [NUM_REQ-1:0]        req_taken,
  output logic                      wb_valid,
  output logic [DATA_W-1:0]         wb_data,
  output logic [IDX_W-1:0]          wb_idx,
  output logic                      br_resolved,
  output logic                      br_taken,
  output logic [NUM_REQ-1:0]        pending
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Slot storage
  logic [NUM_REQ-1:0]             slot_full_q,  slot_full_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data_q,  slot_data_d;
  logic [NUM_REQ-1:0][IDX_W-1:0]  slot_idx_q,   slot_idx_d;
  logic [NUM_REQ-1:0]             slot_br_q,    slot_br_d;
  logic [NUM_REQ-1:0]             slot_taken_q, slot_taken_d;
  logic [PTR_W-1:0]               rr_ptr_q,     rr_ptr_d;

  // Registered outputs
  logic              wb_valid_q,    wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,     wb_data_d;
  logic [IDX_W-1:0]  wb_idx_q,      wb_idx_d;
  logic              br_resolved_q, br_resolved_d;
  logic              br_taken_q,    br_taken_d;

  // Grant
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] accept;

  // Round-robin scan starting at rr_ptr. The first hit wins. With branch
  // priority enabled, a branch-only pass runs first and the plain pass only
  // matters when no branch slot is full.
  always_comb begin : grant_scan
    int               k;
    logic [PTR_W-1:0] kk;
    k         = 0;
    kk        = '0;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef FAST_WB_BRANCH_PRIO_EN
    for (int off = 0; off < NUM_REQ; off++) begin
      k = int'(rr_ptr_q) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = PTR_W'(k);
      if (!grant_any && slot_full_q[kk] && slot_br_q[kk]) begin
        grant_any = 1'b1;
        grant_idx = kk;
      end
    end
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      k = int'(rr_ptr_q) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = PTR_W'(k);
      if (!grant_any && slot_full_q[kk]) begin
        grant_any = 1'b1;
        grant_idx = kk;
      end
    end
  end

  always_comb begin : grant_decode
    grant_oh = '0;
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready = {NUM_REQ{~flush}} & (~slot_full_q | grant_oh);
  assign accept    = req_valid & req_ready;

  always_comb begin : next_state
    slot_full_d   = slot_full_q;
    slot_data_d   = slot_data_q;
    slot_idx_d    = slot_idx_q;
    slot_br_d     = slot_br_q;
    slot_taken_d  = slot_taken_q;
    rr_ptr_d      = rr_ptr_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_idx_d      = wb_idx_q;
    br_resolved_d = 1'b0;
    br_taken_d    = br_taken_q;

    if (flush) begin
      // The grant computed this cycle is dropped along with every slot.
      slot_full_d = '0;
      rr_ptr_d    = '0;
    end else begin
      if (grant_any) begin
        if (int'(grant_idx) == NUM_REQ - 1) rr_ptr_d = '0;
        else                                rr_ptr_d = grant_idx + PTR_W'(1);
        slot_full_d[grant_idx] = 1'b0;
        if (slot_br_q[grant_idx]) begin
          br_resolved_d = 1'b1;
          br_taken_d    = slot_taken_q[grant_idx];
        end else begin
          wb_valid_d = 1'b1;
          wb_data_d  = slot_data_q[grant_idx];
          wb_idx_d   = slot_idx_q[grant_idx];
        end
      end
      // Captures come after the clear so a same-edge refill wins.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_full_d[i]  = 1'b1;
          slot_data_d[i]  = req_data[i*DATA_W +: DATA_W];
          slot_idx_d[i]   = req_idx[i*IDX_W +: IDX_W];
          slot_br_d[i]    = req_is_br[i];
          slot_taken_d[i] = req_is_br[i] & req_taken[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full_q   <= '0;
      slot_data_q   <= '0;
      slot_idx_q    <= '0;
      slot_br_q     <= '0;
      slot_taken_q  <= '0;
      rr_ptr_q      <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_idx_q      <= '0;
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
    end else begin
      slot_full_q   <= slot_full_d;
      slot_data_q   <= slot_data_d;
      slot_idx_q    <= slot_idx_d;
      slot_br_q     <= slot_br_d;
      slot_taken_q  <= slot_taken_d;
      rr_ptr_q      <= rr_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_idx_q      <= wb_idx_d;
      br_resolved_q <= br_resolved_d;
      br_taken_q    <= br_taken_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_idx      = wb_idx_q;
  assign br_resolved = br_resolved_q;
  assign br_taken    = br_taken_q;
  assign pending     = slot_full_q;

endmodule

// File: tb/tb_fast_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fast_wb_arbiter
//
// Bench for fast_wb_arbiter. It runs directed scenarios followed by randomized
// traffic. A behavioural model tracks per-lane slots and the round-robin
// pointer as plain arrays and integers. On every edge, the model pushes the
// expected output record into exp_q. The bench compares that record and the
// slot mask against the DUT.
// -----------------------------------------------------------------------------
module tb_fast_wb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 6;
  localparam int REC_W   = 3 + IDX_W + DATA_W;

  logic                      clk;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*IDX_W-1:0]  req_idx;
  logic [NUM_REQ-1:0]        req_is_br;
  logic [NUM_REQ-1:0]        req_taken;
  logic                      wb_valid;
  logic [DATA_W-1:0]         wb_data;
  logic [IDX_W-1:0]          wb_idx;
  logic                      br_resolved;
  logic                      br_taken;
  logic [NUM_REQ-1:0]        pending;

  fast_wb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_idx     (req_idx),
    .req_is_br   (req_is_br),
    .req_taken   (req_taken),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_idx      (wb_idx),
    .br_resolved (br_resolved),
    .br_taken    (br_taken),
    .pending     (pending)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [REC_W-1:0]   exp_q[$];
  logic [NUM_REQ-1:0] obs_ready;

  // Model: one slot per lane, a round-robin pointer, and the last output values.
  bit                m_full  [NUM_REQ];
  logic [DATA_W-1:0] m_data  [NUM_REQ];
  logic [IDX_W-1:0]  m_idx   [NUM_REQ];
  bit                m_br    [NUM_REQ];
  bit                m_taken [NUM_REQ];
  int                m_rr;
  logic              m_wb_valid;
  logic [DATA_W-1:0] m_wb_data;
  logic [IDX_W-1:0]  m_wb_idx;
  logic              m_br_res;
  logic              m_br_taken;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_grant();
`ifdef FAST_WB_BRANCH_PRIO_EN
    for (int off = 0; off < NUM_REQ; off++) begin
      if (m_full[(m_rr + off) % NUM_REQ] && m_br[(m_rr + off) % NUM_REQ])
        return (m_rr + off) % NUM_REQ;
    end
`endif
    for (int off = 0; off < NUM_REQ; off++) begin
      if (m_full[(m_rr + off) % NUM_REQ]) return (m_rr + off) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_ready();
    logic [NUM_REQ-1:0] r;
    int g;
    g = model_grant();
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) r[i] = !flush && (!m_full[i] || g == i);
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_pending();
    logic [NUM_REQ-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) p[i] = m_full[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      m_full[i]  = 0;
      m_data[i]  = '0;
      m_idx[i]   = '0;
      m_br[i]    = 0;
      m_taken[i] = 0;
    end
    m_rr       = 0;
    m_wb_valid = 1'b0;
    m_wb_data  = '0;
    m_wb_idx   = '0;
    m_br_res   = 1'b0;
    m_br_taken = 1'b0;
    exp_q.delete();
  endtask

  // Applies one clock edge using the inputs held across that edge.
  task automatic model_edge();
    int g;
    logic [NUM_REQ-1:0] rdy;
    g   = model_grant();
    rdy = model_ready();
    m_wb_valid = 1'b0;
    m_br_res   = 1'b0;
    if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) m_full[i] = 0;
      m_rr = 0;
    end else begin
      if (g >= 0) begin
        if (m_br[g]) begin
          m_br_res   = 1'b1;
          m_br_taken = m_taken[g];
        end else begin
          m_wb_valid = 1'b1;
          m_wb_data  = m_data[g];
          m_wb_idx   = m_idx[g];
        end
        m_full[g] = 0;
        m_rr      = (g + 1) % NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && rdy[i]) begin
          m_full[i]  = 1;
          m_data[i]  = req_data[i*DATA_W +: DATA_W];
          m_idx[i]   = req_idx[i*IDX_W +: IDX_W];
          m_br[i]    = req_is_br[i];
          m_taken[i] = req_is_br[i] && req_taken[i];
        end
      end
    end
    exp_q.push_back({m_wb_valid, m_br_res, m_br_taken, m_wb_idx, m_wb_data});
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req_valid = '0;
    req_data  = '0;
    req_idx   = '0;
    req_is_br = '0;
    req_taken = '0;
  endtask

  task automatic set_lane(input int i, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] x,
                          input logic br, input logic tk);
    req_valid[i]                = 1'b1;
    req_data[i*DATA_W +: DATA_W] = d;
    req_idx[i*IDX_W +: IDX_W]   = x;
    req_is_br[i]                = br;
    req_taken[i]                = tk;
  endtask

  // Called at posedge+1; returns at the next posedge+1 after all checks.
  task automatic cycle();
    logic [REC_W-1:0] e;
    #1;
    obs_ready = req_ready;
    check("req_ready", req_ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check("wb_valid",    wb_valid,    e[REC_W-1]);
    check("br_resolved", br_resolved, e[DATA_W+IDX_W+1]);
    check("br_taken",    br_taken,    e[DATA_W+IDX_W]);
    check("wb_idx",      wb_idx,      e[DATA_W +: IDX_W]);
    check("wb_data",     wb_data,     e[DATA_W-1:0]);
    check("pending",     pending,     model_pending());
  endtask

  // Asserts reset between edges, then releases it at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_br_res",   br_resolved, 1'b0);
    check("rst_pending",  pending, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wb_count;
    rst_n = 1'b0;
    flush = 1'b0;
    clear_inputs();
    do_reset();
    check("rst_wb_data",  wb_data,  '0);
    check("rst_wb_idx",   wb_idx,   '0);
    check("rst_br_taken", br_taken, 1'b0);

    // Single beat on lane 2
    set_lane(2, 32'h1234, 6'd5, 1'b0, 1'b0);
    cycle();
    check("t1_pending_after_accept", pending, 4'b0100);
    clear_inputs();
    cycle();
    check("t1_wb_valid", wb_valid, 1'b1);
    check("t1_wb_data",  wb_data,  32'h1234);
    check("t1_wb_idx",   wb_idx,   6'd5);
    check("t1_pending",  pending,  4'b0000);
    cycle();
    check("t1_wb_valid_drop", wb_valid, 1'b0);

    // All four lanes at once: grants 0,1,2,3
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'hA0 + i, IDX_W'(10 + i), 1'b0, 1'b0);
    cycle();
    clear_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      cycle();
      check("t2_wb_valid", wb_valid, 1'b1);
      check("t2_wb_idx",   wb_idx,   IDX_W'(10 + i));
    end
    cycle();
    check("t2_idle", wb_valid, 1'b0);

    // Lane 1 streams 8 back-to-back beats
    do_reset();
    wb_count = 0;
    for (int b = 0; b < 8; b++) begin
      set_lane(1, 32'hB000 + b, IDX_W'(b), 1'b0, 1'b0);
      cycle();
      check("t3_ready1", obs_ready[1], 1'b1);
      if (wb_valid) wb_count++;
    end
    clear_inputs();
    for (int b = 0; b < 3; b++) begin
      cycle();
      if (wb_valid) wb_count++;
    end
    check("t3_wb_count", wb_count, 8);

    // Branch on lane 3 and result on lane 0
    do_reset();
    set_lane(0, 32'hBEEF, 6'd7, 1'b0, 1'b0);
    set_lane(3, 32'h0,    6'd9, 1'b1, 1'b1);
    cycle();
    clear_inputs();
    cycle();
`ifdef FAST_WB_BRANCH_PRIO_EN
    check("t4_first_br",    br_resolved, 1'b1);
    check("t4_first_taken", br_taken,    1'b1);
    cycle();
    check("t4_second_wb",   wb_valid,    1'b1);
    check("t4_second_data", wb_data,     32'hBEEF);
`else
    check("t4_first_wb",    wb_valid,    1'b1);
    check("t4_first_data",  wb_data,     32'hBEEF);
    cycle();
    check("t4_second_br",   br_resolved, 1'b1);
    check("t4_second_taken", br_taken,   1'b1);
    check("t4_second_nowb", wb_valid,    1'b0);
`endif
    cycle();

    // Flush with three full slots and a beat on lane 0
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 32'hC0 + i, IDX_W'(20 + i), 1'b0, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("t5_three_full", pending, 4'b1110);
    flush = 1'b1;
    set_lane(0, 32'hDEAD, 6'd33, 1'b0, 1'b0);
    cycle();
    check("t5_ready_low", obs_ready, 4'b0000);
    check("t5_pending",   pending,   4'b0000);
    check("t5_wb_valid",  wb_valid,  1'b0);
    check("t5_br_res",    br_resolved, 1'b0);
    flush = 1'b0;
    clear_inputs();
    set_lane(0, 32'hE0, 6'd40, 1'b0, 1'b0);
    set_lane(3, 32'hE3, 6'd43, 1'b0, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("t5_rr_zero", wb_idx, 6'd40);
    cycle();
    check("t5_next",    wb_idx, 6'd43);

    // Asynchronous reset mid-stream with two slots full
    do_reset();
    for (int i = 0; i < 3; i++) set_lane(i, 32'hF0 + i, IDX_W'(50 + i), 1'b0, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("t6_pre_valid",   wb_valid, 1'b1);
    check("t6_pre_pending", pending,  4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_valid",   wb_valid, 1'b0);
    check("t6_async_pending", pending,  4'b0000);
    check("t6_async_data",    wb_data,  '0);
    check("t6_async_idx",     wb_idx,   '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_lane(3, 32'h3333, 6'd60, 1'b0, 1'b0);
    cycle();
    clear_inputs();
    cycle();
    check("t6_lane3_valid", wb_valid, 1'b1);
    check("t6_lane3_idx",   wb_idx,   6'd60);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      clear_inputs();
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 1) == 1)
          set_lane(i, $urandom, IDX_W'($urandom_range(0, 63)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        flush = 1'b0;
        do_reset();
      end else begin
        cycle();
      end
    end
    flush = 1'b0;
    clear_inputs();
    repeat (NUM_REQ + 1) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
